// File: rtl/payload_char_feeder_if.sv
`default_nettype none
// ============================================================================
//  Module      : payload_char_feeder_if
//  Description : Payload word stream (AXI-Stream style) between the packet
//                source and the character feeder of the payload engine array.
//  Revision    : 1.0 - initial release
// ============================================================================
interface payload_char_feeder_if #(
    parameter int DATA_WIDTH = 64
);
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tlast;
    logic                    tvalid;
    logic                    tready;

    modport master (output tdata, tkeep, tlast, tvalid, input tready);
    modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface
`default_nettype wire

// File: rtl/payload_char_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : payload_char_feeder
//  Description : Serializes 64-bit payload words to one byte per clock and
//                maps each byte to a character-class vector through a
//                programmable 256-entry table. Class bit 0 is the multiline
//                line-start anchor. Drives sod/en/in_N of the engine array.
//  Revision    : 1.0 - initial release
// ============================================================================
module payload_char_feeder #(
    parameter int DATA_WIDTH  = 64,
    parameter int NUM_CLASSES = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    payload_char_feeder_if.slave   s,
    input  logic                   cfg_we,
    input  logic [7:0]             cfg_addr,
    input  logic [NUM_CLASSES-1:0] cfg_wdata,
    output logic                   sod,
    output logic                   en,
    output logic [NUM_CLASSES-1:0] class_vec,
    output logic [7:0]             byte_out,
    output logic                   eod
);

    localparam int LANES = DATA_WIDTH / 8;
    localparam int IDX_W = $clog2(LANES);
    localparam int CNT_W = IDX_W + 1;
    localparam int TBL_W = NUM_CLASSES - 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SOD   = 2'd1,
        ST_BYTES = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    state_t                r_state;
    logic                  r_tready;
    logic [DATA_WIDTH-1:0] r_data;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_last;
    logic [IDX_W-1:0]      r_idx;

    // Byte-select stage
    logic                  r_s1_valid;
    logic                  r_s1_sod;
    logic                  r_s1_eod;
    logic [7:0]            r_s1_byte;

    // Anchor state: next emitted byte starts a line
    logic                  r_line_start;

    // Class table (bit 0 of the class vector is not stored)
    logic [TBL_W-1:0]      r_tbl [0:255];

    logic [CNT_W-1:0]      w_cnt;
    logic                  w_accept;
    logic                  w_last_beat;
    logic                  w_single;

    assign s.tready    = r_tready;
    assign w_accept    = s.tvalid && r_tready;
    assign w_single    = (w_cnt <= CNT_W'(1));
    assign w_last_beat = (r_cnt == '0) || ((CNT_W'(r_idx) + CNT_W'(1)) == r_cnt);

    // Valid byte count = run of ones in tkeep starting at lane 0
    always_comb begin
        w_cnt = CNT_W'(LANES);
        for (int i = LANES - 1; i >= 0; i--) begin
            if (!s.tkeep[i]) begin
                w_cnt = CNT_W'(i);
            end
        end
    end

    // Serializer FSM: holds one word, emits one byte per cycle into stage 1.
    // tready is registered, so it is computed for the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_tready   <= 1'b0;
            r_data     <= '0;
            r_cnt      <= '0;
            r_last     <= 1'b0;
            r_idx      <= '0;
            r_s1_valid <= 1'b0;
            r_s1_sod   <= 1'b0;
            r_s1_eod   <= 1'b0;
            r_s1_byte  <= '0;
        end else begin
            r_s1_valid <= 1'b0;
            r_s1_sod   <= 1'b0;
            r_s1_eod   <= 1'b0;
            r_s1_byte  <= '0;
            case (r_state)
                ST_IDLE: begin
                    r_tready <= 1'b1;
                    if (w_accept) begin
                        r_data   <= s.tdata;
                        r_cnt    <= w_cnt;
                        r_last   <= s.tlast;
                        r_state  <= ST_SOD;
                        r_tready <= 1'b0;
                    end
                end
                ST_SOD: begin
                    r_s1_sod <= 1'b1;
                    r_idx    <= '0;
                    r_state  <= ST_BYTES;
                    r_tready <= (r_cnt <= CNT_W'(1));
                end
                ST_BYTES: begin
                    // A zero-byte word emits nothing but may still close the packet
                    if (r_cnt != '0) begin
                        r_s1_valid <= 1'b1;
                        r_s1_byte  <= r_data[{r_idx, 3'b000} +: 8];
                    end
                    r_s1_eod <= w_last_beat && r_last;
                    if (w_last_beat) begin
                        if (w_accept) begin
                            r_data <= s.tdata;
                            r_cnt  <= w_cnt;
                            r_last <= s.tlast;
                            r_idx  <= '0;
                            if (r_last) begin
                                r_state  <= ST_SOD;
                                r_tready <= 1'b0;
                            end else begin
                                r_state  <= ST_BYTES;
                                r_tready <= w_single;
                            end
                        end else begin
                            r_state  <= r_last ? ST_IDLE : ST_WAIT;
                            r_tready <= 1'b1;
                        end
                    end else begin
                        r_idx    <= r_idx + IDX_W'(1);
                        r_tready <= ((CNT_W'(r_idx) + CNT_W'(2)) == r_cnt);
                    end
                end
                ST_WAIT: begin
                    r_tready <= 1'b1;
                    if (w_accept) begin
                        r_data   <= s.tdata;
                        r_cnt    <= w_cnt;
                        r_last   <= s.tlast;
                        r_idx    <= '0;
                        r_state  <= ST_BYTES;
                        r_tready <= w_single;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_tready <= 1'b0;
                end
            endcase
        end
    end

    // Class table write port; contents survive reset
    always_ff @(posedge clk) begin
        if (cfg_we) begin
            r_tbl[cfg_addr] <= TBL_W'(cfg_wdata >> 1);
        end
    end

    // Output stage: synchronous table read (read-first) and anchor calculation
    always_ff @(posedge clk) begin
        if (rst) begin
            sod          <= 1'b0;
            en           <= 1'b0;
            eod          <= 1'b0;
            byte_out     <= '0;
            class_vec    <= '0;
            r_line_start <= 1'b0;
        end else begin
            sod       <= r_s1_sod;
            en        <= r_s1_valid;
            eod       <= r_s1_eod;
            byte_out  <= r_s1_byte;
            class_vec <= r_s1_valid ? {r_tbl[r_s1_byte], r_line_start} : '0;
            if (r_s1_sod) begin
                r_line_start <= 1'b1;
            end else if (r_s1_valid) begin
                r_line_start <= (r_s1_byte == 8'h0A);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_payload_char_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_payload_char_feeder
//  Description : Directed self-checking bench for payload_char_feeder.
//                Outputs are logged per cycle at the falling edge; each task
//                sends words and then compares the log against hand values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_payload_char_feeder;

    localparam int LOGN = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [7:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic        sod, en, eod;
    logic [31:0] class_vec;
    logic [7:0]  byte_out;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic        lg_sod [0:LOGN-1];
    logic        lg_en  [0:LOGN-1];
    logic        lg_eod [0:LOGN-1];
    logic        lg_tr  [0:LOGN-1];
    logic [31:0] lg_cv  [0:LOGN-1];
    logic [7:0]  lg_bo  [0:LOGN-1];

    payload_char_feeder_if #(.DATA_WIDTH(64)) s_if ();

    payload_char_feeder #(.DATA_WIDTH(64), .NUM_CLASSES(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .s         (s_if),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .sod       (sod),
        .en        (en),
        .class_vec (class_vec),
        .byte_out  (byte_out),
        .eod       (eod)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle log of outputs, captured mid-cycle
    always @(negedge clk) begin
        if (cyc < LOGN) begin
            lg_sod[cyc] = sod;
            lg_en[cyc]  = en;
            lg_eod[cyc] = eod;
            lg_tr[cyc]  = s_if.tready;
            lg_cv[cyc]  = class_vec;
            lg_bo[cyc]  = byte_out;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_tbl(input logic [7:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick(1);
        cfg_we = 1'b0;
    endtask

    // Offer one word; returns the cycle number of the accepting edge
    task automatic send(input logic [63:0] d, input logic [7:0] k, input logic l, output int acc);
        int guard;
        guard = 0;
        s_if.tdata = d; s_if.tkeep = k; s_if.tlast = l; s_if.tvalid = 1'b1;
        @(negedge clk);
        while (s_if.tready !== 1'b1) begin
            guard++;
            if (guard > 100) begin
                $display("FAIL send_timeout: tready stayed %b, required 1", s_if.tready);
                $fatal(1, "handshake timeout");
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        acc = cyc;
        s_if.tvalid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        checks++;
        if (s_if.tready !== 1'b0) begin
            failures++; $display("FAIL reset_tready: got %b required 0", s_if.tready);
        end
        checks++;
        if ({sod, en, eod, class_vec, byte_out} !== 43'd0) begin
            failures++; $display("FAIL reset_outputs: got %h required 0", {sod, en, eod, class_vec, byte_out});
        end
        rst = 1'b0;
        tick(1);
        checks++;
        if (s_if.tready !== 1'b1) begin
            failures++; $display("FAIL reset_release_tready: got %b required 1", s_if.tready);
        end
    endtask

    task automatic init_table();
        for (int i = 0; i < 256; i++) write_tbl(8'(i), 32'd0);
    endtask

    task automatic test_single_word();
        int a;
        logic [31:0] ecv [0:3];
        ecv[0] = 32'h7; ecv[1] = 32'h6; ecv[2] = 32'h6; ecv[3] = 32'h0;
        write_tbl(8'h41, 32'h0000_0006);
        send(64'h0000_0000_0A41_4141, 8'h0F, 1'b1, a);
        tick(12);
        for (int k = 0; k <= 8; k++) begin
            checks++;
            if (lg_sod[a+k] !== (k == 2)) begin
                failures++; $display("FAIL single_sod[%0d]: got %b required %b", k, lg_sod[a+k], (k == 2));
            end
            checks++;
            if (lg_en[a+k] !== (k >= 3 && k <= 6)) begin
                failures++; $display("FAIL single_en[%0d]: got %b required %b", k, lg_en[a+k], (k >= 3 && k <= 6));
            end
            checks++;
            if (lg_eod[a+k] !== (k == 6)) begin
                failures++; $display("FAIL single_eod[%0d]: got %b required %b", k, lg_eod[a+k], (k == 6));
            end
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (lg_cv[a+3+k] !== ecv[k]) begin
                failures++; $display("FAIL single_class[%0d]: got %h required %h", k, lg_cv[a+3+k], ecv[k]);
            end
        end
        checks++;
        if (lg_bo[a+6] !== 8'h0A) begin
            failures++; $display("FAIL single_byte3: got %h required 0a", lg_bo[a+6]);
        end
    endtask

    task automatic test_two_word();
        int a, b, nsod;
        send(64'h0706_0504_0302_0100, 8'hFF, 1'b0, a);
        send(64'h0000_0000_0000_0008, 8'h01, 1'b1, b);
        tick(14);
        checks++;
        if (b !== a + 9) begin
            failures++; $display("FAIL two_accept2: got cycle %0d required %0d", b, a + 9);
        end
        for (int k = 0; k < 9; k++) begin
            checks++;
            if (lg_en[a+3+k] !== 1'b1 || lg_bo[a+3+k] !== 8'(k)) begin
                failures++; $display("FAIL two_byte[%0d]: got en=%b byte=%h required en=1 byte=%h", k, lg_en[a+3+k], lg_bo[a+3+k], 8'(k));
            end
            checks++;
            if (lg_eod[a+3+k] !== (k == 8)) begin
                failures++; $display("FAIL two_eod[%0d]: got %b required %b", k, lg_eod[a+3+k], (k == 8));
            end
        end
        checks++;
        if (lg_en[a+12] !== 1'b0) begin
            failures++; $display("FAIL two_en_after: got %b required 0", lg_en[a+12]);
        end
        nsod = 0;
        for (int k = 0; k <= 13; k++) nsod += int'(lg_sod[a+k]);
        checks++;
        if (nsod !== 1) begin
            failures++; $display("FAIL two_sod_count: got %0d required 1", nsod);
        end
        checks++;
        if (lg_tr[a+7] !== 1'b0 || lg_tr[a+8] !== 1'b1) begin
            failures++; $display("FAIL two_tready_byte7: got %b%b required 01", lg_tr[a+7], lg_tr[a+8]);
        end
        checks++;
        if (lg_cv[a+3] !== 32'h1 || lg_cv[a+4] !== 32'h0) begin
            failures++; $display("FAIL two_anchor: got %h,%h required 1,0", lg_cv[a+3], lg_cv[a+4]);
        end
    endtask

    task automatic test_newline();
        int a;
        logic [31:0] ecv [0:4];
        logic [7:0]  ebo [0:4];
        ecv[0] = 32'h1; ecv[1] = 32'h0; ecv[2] = 32'h11; ecv[3] = 32'h0; ecv[4] = 32'h8000_0000;
        ebo[0] = 8'h78; ebo[1] = 8'h0A; ebo[2] = 8'h47; ebo[3] = 8'h45; ebo[4] = 8'h54;
        write_tbl(8'h47, 32'h0000_0010);
        write_tbl(8'h54, 32'h8000_0001);
        send(64'h0000_0054_4547_0A78, 8'h1F, 1'b1, a);
        tick(10);
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (lg_cv[a+3+k] !== ecv[k] || lg_bo[a+3+k] !== ebo[k]) begin
                failures++; $display("FAIL newline_byte[%0d]: got cv=%h byte=%h required cv=%h byte=%h", k, lg_cv[a+3+k], lg_bo[a+3+k], ecv[k], ebo[k]);
            end
        end
        checks++;
        if (lg_eod[a+7] !== 1'b1 || lg_eod[a+6] !== 1'b0) begin
            failures++; $display("FAIL newline_eod: got %b%b required 01", lg_eod[a+6], lg_eod[a+7]);
        end
    endtask

    task automatic test_back_to_back();
        int a, b, nsod;
        send(64'h0000_0000_0000_4241, 8'h03, 1'b1, a);
        send(64'h0000_0000_0000_0041, 8'h01, 1'b1, b);
        tick(10);
        checks++;
        if (b !== a + 3) begin
            failures++; $display("FAIL b2b_accept: got cycle %0d required %0d", b, a + 3);
        end
        checks++;
        if (lg_eod[a+4] !== 1'b1 || lg_en[a+4] !== 1'b1 || lg_bo[a+4] !== 8'h42) begin
            failures++; $display("FAIL b2b_a_eod: got eod=%b en=%b byte=%h required 1 1 42", lg_eod[a+4], lg_en[a+4], lg_bo[a+4]);
        end
        checks++;
        if (lg_sod[a+5] !== 1'b1 || lg_en[a+5] !== 1'b0) begin
            failures++; $display("FAIL b2b_sod: got sod=%b en=%b required 1 0", lg_sod[a+5], lg_en[a+5]);
        end
        checks++;
        if (lg_en[a+6] !== 1'b1 || lg_cv[a+6] !== 32'h7 || lg_eod[a+6] !== 1'b1) begin
            failures++; $display("FAIL b2b_b_byte0: got en=%b cv=%h eod=%b required 1 7 1", lg_en[a+6], lg_cv[a+6], lg_eod[a+6]);
        end
        nsod = 0;
        for (int k = 3; k <= 9; k++) nsod += int'(lg_sod[a+k]);
        checks++;
        if (nsod !== 1) begin
            failures++; $display("FAIL b2b_sod_count: got %0d required 1", nsod);
        end
    endtask

    task automatic test_reset_mid();
        int a, b, neod;
        send(64'h4141_4141_4141_4141, 8'hFF, 1'b0, a);
        tick(5);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(3);
        checks++;
        if (lg_en[a+5] !== 1'b1) begin
            failures++; $display("FAIL rstmid_third_byte: got en=%b required 1", lg_en[a+5]);
        end
        for (int k = 6; k <= 7; k++) begin
            checks++;
            if ({lg_sod[a+k], lg_en[a+k], lg_eod[a+k], lg_cv[a+k], lg_bo[a+k], lg_tr[a+k]} !== 44'd0) begin
                failures++; $display("FAIL rstmid_outputs[%0d]: got %h required 0", k, {lg_sod[a+k], lg_en[a+k], lg_eod[a+k], lg_cv[a+k], lg_bo[a+k], lg_tr[a+k]});
            end
        end
        neod = 0;
        for (int k = 0; k <= 9; k++) neod += int'(lg_eod[a+k]);
        checks++;
        if (neod !== 0) begin
            failures++; $display("FAIL rstmid_no_eod: got %0d required 0", neod);
        end
        send(64'h0000_0000_0000_0041, 8'h01, 1'b1, b);
        tick(6);
        checks++;
        if (lg_sod[b+2] !== 1'b1 || lg_en[b+3] !== 1'b1) begin
            failures++; $display("FAIL rstmid_new_sod: got sod=%b en=%b required 1 1", lg_sod[b+2], lg_en[b+3]);
        end
        checks++;
        if (lg_cv[b+3] !== 32'h7) begin
            failures++; $display("FAIL rstmid_table_kept: got %h required 7", lg_cv[b+3]);
        end
    endtask

    task automatic test_zero_byte();
        int a, c, b;
        send(64'h1716_1514_1312_1110, 8'hFF, 1'b0, a);
        send(64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 1'b1, c);
        tick(6);
        checks++;
        if (c !== a + 9) begin
            failures++; $display("FAIL zero_accept: got cycle %0d required %0d", c, a + 9);
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (lg_en[a+3+k] !== 1'b1 || lg_eod[a+3+k] !== 1'b0 || lg_bo[a+3+k] !== 8'(8'h10 + k)) begin
                failures++; $display("FAIL zero_byte[%0d]: got en=%b eod=%b byte=%h required 1 0 %h", k, lg_en[a+3+k], lg_eod[a+3+k], lg_bo[a+3+k], 8'(8'h10 + k));
            end
        end
        checks++;
        if (lg_eod[a+11] !== 1'b1 || lg_en[a+11] !== 1'b0 || lg_cv[a+11] !== 32'h0 || lg_bo[a+11] !== 8'h0) begin
            failures++; $display("FAIL zero_lone_eod: got eod=%b en=%b cv=%h byte=%h required 1 0 0 0", lg_eod[a+11], lg_en[a+11], lg_cv[a+11], lg_bo[a+11]);
        end
        checks++;
        if (lg_eod[a+12] !== 1'b0) begin
            failures++; $display("FAIL zero_eod_len: got %b required 0", lg_eod[a+12]);
        end
        send(64'h0000_0000_0000_0041, 8'h01, 1'b1, b);
        tick(6);
        checks++;
        if (lg_sod[b+2] !== 1'b1 || lg_en[b+3] !== 1'b1 || lg_cv[b+3] !== 32'h7) begin
            failures++; $display("FAIL zero_next_pkt: got sod=%b en=%b cv=%h required 1 1 7", lg_sod[b+2], lg_en[b+3], lg_cv[b+3]);
        end
    endtask

    initial begin
        rst = 1'b1;
        cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        s_if.tdata = '0; s_if.tkeep = '0; s_if.tlast = 1'b0; s_if.tvalid = 1'b0;
        test_reset();
        init_table();
        tick(2);
        test_single_word();
        test_two_word();
        test_newline();
        test_back_to_back();
        test_reset_mid();
        test_zero_byte();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/payload_char_feeder.md
# payload_char_feeder

Front end of the payload engine array. Accepts packet payload as 64-bit stream words, serializes them to one byte per clock, and maps each byte to a 32-bit character-class vector through a programmable 256-entry table. Drives the `clk`/`sod`/`en`/`in_N` inputs shared by every `engine_*` instance. Class 0 is reserved for the multiline line-start anchor (`^` under `/m`).

## Interface
Parameters:
- `DATA_WIDTH`, default 64: stream word width. Fixed at 64.
- `NUM_CLASSES`, default 32: width of `class_vec`. Bit 0 is the anchor; bits 1..31 come from the table.

Ports:
- `clk`  in  1  clock. This is the block's only clock.
- `rst`  in  1  reset. Synchronous and active-high.
- `s_tdata`  in  64  payload word. Lane 0 is bits [7:0] and is the first byte.
- `s_tkeep`  in  8  byte-lane valid.
- `s_tlast`  in  1  last word of the packet.
- `s_tvalid`  in  1  word valid.
- `s_tready`  out  1  word accepted on any edge where `s_tvalid && s_tready`.
- `cfg_we`  in  1  class-table write strobe.
- `cfg_addr`  in  8  byte value whose entry is written.
- `cfg_wdata`  in  32  class bitmap. Bit 0 is ignored.
- `sod`  out  1  start-of-data pulse, i.e. engine state clear.
- `en`  out  1  one pulse per emitted byte.
- `class_vec`  out  32  class hits for the current byte. Feeds engine `in_N`.
- `byte_out`  out  8  the current byte, for debug and capture.
- `eod`  out  1  last byte of the packet.

## Operation
Byte count per word:
- The count is the number of contiguous ones in `s_tkeep` starting at lane 0.
- Lanes at or above the first zero are discarded.
- A word with `s_tkeep[0]=0` contributes no bytes.

Serializer FSM states: IDLE, SOD, BYTES, WAIT.
- IDLE: no packet open, `s_tready=1`. An accepted word goes to SOD.
- SOD: issues the `sod` pulse. `en` is 0 in this cycle. Next state is BYTES, starting at index 0.
- BYTES: emits one byte per cycle, lane 0 upward. On the last byte of the held word, `s_tready=1`.
  - Held word had tlast, and a new word is accepted in the same cycle: go to SOD.
  - Held word had tlast, and no word is accepted: go to IDLE.
  - Held word had no tlast, and a word is accepted: stay in BYTES at index 0. There is no bubble.
  - Held word had no tlast, and no word is accepted: go to WAIT.
- WAIT: packet is open and the holding register is empty, `s_tready=1`. An accepted word goes to BYTES with no `sod`.
- A zero-byte word is consumed in one cycle.
  - If it carries tlast, the block emits a single `eod` pulse with `en=0` and closes the packet.
  - A zero-byte first word of a packet still produces `sod`.

Anchor (`class_vec[0]`):
- It is 1 on the first byte of the packet.
- It is 1 on any byte whose predecessor in the same packet was 0x0A.
- It is 0 otherwise.

Class table:
- 256 x 31 synchronous RAM. `class_vec[31:1] = table[byte]`.
- A write with `cfg_we=1` stores `cfg_wdata[31:1]` at `cfg_addr`.
- A same-cycle write and read of the same address returns the old data (read-first).
- The table is not cleared by `rst`. Its initial content is all zero.
- Table writes during traffic are legal. They affect the bytes read on the following cycles.

Outputs:
- All outputs are registered.
- When `en=0`, `class_vec`, `byte_out` and `eod` are 0. The one exception is the zero-byte tlast `eod` pulse.
- `eod` coincides with `en` on the last byte.

Reset:
- While `rst=1`, and in the cycle it is sampled: all outputs are 0, `s_tready=0`, the FSM goes to IDLE, and pipeline valids clear.
- `s_tready` rises in the first cycle after `rst` deasserts.
- Reset mid-packet drops the held and in-flight bytes without `eod`. The next accepted word starts a new packet with `sod`.

## Timing
Latency, with the accepting edge taken as cycle 0:
- `sod` is high in cycle 2.
- Byte k of the first word has `en=1` in cycle 3+k.
- The pipeline is 2 stages: byte select, then table read with anchor calculation. `sod` and `eod` travel through the same stages as the bytes.

Throughput:
- Within a packet, 1 byte per clock while the source keeps up.
- Exactly one non-`en` bubble (the `sod` cycle) per packet.

Engine interface rules:
- `sod` never coincides with `en`.
- `sod` is exactly 1 cycle long.
- `sod` always comes one cycle before the packet's first `en`.

## Test plan
- Table 'A'(0x41)=0x0000_0006. Send one word 0x0A41_4141 with tkeep 0x0F and tlast.
  - `sod` in cycle 2.
  - `en` in cycles 3–6.
  - `class_vec` sequence: 0x7, 0x6, 0x6, 0x0.
  - `eod` with the 4th byte.
- Two-word packet: full tkeep without tlast, then 0x01 with tlast, offered back-to-back.
  - 9 consecutive `en` cycles and a single `sod`.
  - `s_tready` high in the cycle of byte 7.
- Newline anchor: payload "x\nGET". The 'G' byte has bit 0 set; 'E' and 'T' do not.
- Packet B presented in the same cycle as packet A's last byte.
  - A's `eod`, then exactly one idle `sod` cycle, then B's byte 0 with anchor set.
- `rst` asserted mid-word, after 3 of 8 bytes.
  - Outputs go to 0 the next cycle, with no `eod`.
  - The next packet gets a fresh `sod`.
  - Table contents are retained.
- Zero-byte tlast word (tkeep 0x00) after a full word.
  - 8 bytes without `eod`, then a lone `eod` pulse with `en=0`.
  - The next packet starts with `sod`.
